pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Sequences the 5-stage pipeline around the ID-stage decoder: detects RAW hazards between the
//  instruction in IF/ID and older writers in EX/MEM, then stalls IF/ID and PC and injects bubbles
//  into ID/EX. Flushes IF/ID after a taken branch. Keeps a shadow copy of in-flight one-hot dselects.
// PARAMETERS
//  NREG      32  width of one-hot register selects; bit 0 = r0, never a hazard source
//  BR_FLUSH  1   cycles of IF/ID flush after ex_branch_taken (1..7)
//  CNT_W     16  width of hazard_count
// PORTS
//  clk              in   1     rising-edge clock
//  reset            in   1     synchronous, active-high reset
//  id_valid         in   1     IF/ID holds a real instruction
//  id_aselect       in   NREG  one-hot rs of IF/ID instruction
//  id_bselect       in   NREG  one-hot rt of IF/ID instruction
//  id_uses_b        in   1     instruction reads rt (R-type, store, branch); 0 for Imm ALU/load
//  id_dselect       in   NREG  one-hot destination after Imm mux (rt or rd)
//  id_writes        in   1     instruction writes the register file
//  id_load          in   1     instruction is a load
//  ex_branch_taken  in   1     branch in EX resolved taken this cycle
//  stall            out  1     hold PC and IF/ID this cycle
//  bubble           out  1     force ID/EX control (Load, Store, writes, dselect) to zero
//  flush            out  1     clear IF/ID to a NOP at next edge
//  state            out  2     00 RUN, 01 STALL, 10 FLUSH
//  hazard_count     out  CNT_W saturating count of stalled cycles
// BEHAVIOUR
//  - Shadow regs ex_d, mem_d (NREG) and ex_ld (1) advance every edge; the downstream pipe never stalls.
//    ex_d <= (id_valid & id_writes & ~bubble & ~flush) ? id_dselect & ~1 : 0; mem_d <= ex_d.
//  - Reads: rd = id_aselect | (id_uses_b ? id_bselect : 0), bit 0 masked.
//  - The register file writes before it reads in the same cycle, so the WB stage is never a hazard.
//  - hazard = id_valid & |(rd & H). H is set by CONFIGURATION.
//  - Outputs are combinational from the current state and inputs. Zero latency: stall and bubble
//    assert in the same cycle the hazard is visible.
//  - FSM, registered:
//    RUN:   ex_branch_taken -> FLUSH; else hazard -> STALL; else RUN.
//    STALL: ex_branch_taken -> FLUSH; else hazard -> STALL; else RUN.
//    FLUSH: counter loads BR_FLUSH-1 on entry and decrements; id_valid is ignored (treated as 0);
//           exits to RUN when counter = 0 and ex_branch_taken = 0.
//  - flush = ex_branch_taken | (state == FLUSH).
//  - stall = bubble = hazard & ~flush. A branch in EX is older than the stalled instruction, so
//    flush wins.
//  - ex_branch_taken while in FLUSH reloads the counter.
//  - hazard_count increments on every stall = 1 cycle and saturates at all ones.
//  - reset = 1: state = RUN, ex_d = mem_d = 0, ex_ld = 0, counter = 0, hazard_count = 0, and
//    stall = bubble = flush = 0 in that cycle. Reset mid-stall or mid-flush drops immediately to RUN.
// CONFIGURATION
//  Macro PIPE_FORWARD_EN.
//  Defined:   EX/MEM-to-EX forwarding exists. H = ex_ld ? ex_d : 0, i.e. only load-use stalls,
//             at most 1 cycle.
//  Undefined: no forwarding. H = ex_d | mem_d. A dependent instruction stalls up to 2 cycles.
//             ex_ld is still tracked but unused.
// STRUCTURE
//  Package cpu5_ctrl_pkg holds NREG, the state encodings ST_RUN/ST_STALL/ST_FLUSH, and the
//  R0_MASK constant.
//  One sub-module, onehot_hazard_cmp: combinational (rd, H) -> hazard, parameterised by NREG.
//  The FSM, shadow registers and counters stay in the top module.
// TESTING
//  1 Reset held 3 cycles with id_valid = 1 and matching selects: stall/bubble/flush = 0,
//    state = 00, hazard_count = 0.
//  2 No fwd: add r3 (dsel bit 3), then add reading r3 via A -> stall = 1 for 2 cycles, then 0;
//    hazard_count = 2.
//  3 PIPE_FORWARD_EN: same pair -> no stall. Load r5, then use r5 via B with id_uses_b = 1 ->
//    stall = 1 for exactly 1 cycle.
//  4 Imm op, rt = r5 read only via B with id_uses_b = 0, after a write to r5 -> no stall.
//    Writes to r0 never stall.
//  5 ex_branch_taken during STALL -> flush = 1, stall = 0 that cycle, state = FLUSH.
//    With BR_FLUSH = 1, back to RUN after 1 cycle.
//  6 Force hazard for 2^CNT_W+5 cycles -> hazard_count saturates at all ones, no wrap to 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants and types for the 5-stage pipeline hazard controller.
package cpu5_ctrl_pkg;

    localparam int unsigned NREG     = 32;
    localparam int unsigned FL_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    // r0 is hardwired to zero, so it never carries a dependency
    localparam logic [NREG-1:0] R0_MASK = {{(NREG-1){1'b1}}, 1'b0};

    function automatic logic [NREG-1:0] mask_r0(input logic [NREG-1:0] sel);
        return sel & R0_MASK;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// ID-stage decode fields in, pipeline steering controls out.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    import cpu5_ctrl_pkg::*;

    logic              id_valid;
    logic [NREG-1:0]   id_aselect;
    logic [NREG-1:0]   id_bselect;
    logic              id_uses_b;
    logic [NREG-1:0]   id_dselect;
    logic              id_writes;
    logic              id_load;
    logic              ex_branch_taken;
    logic              stall;
    logic              bubble;
    logic              flush;
    logic [1:0]        state;
    logic [CNT_W-1:0]  hazard_count;

    modport slave (
        input  id_valid, id_aselect, id_bselect, id_uses_b, id_dselect,
               id_writes, id_load, ex_branch_taken,
        output stall, bubble, flush, state, hazard_count
    );

    modport master (
        output id_valid, id_aselect, id_bselect, id_uses_b, id_dselect,
               id_writes, id_load, ex_branch_taken,
        input  stall, bubble, flush, state, hazard_count
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_cmp.sv
// One-hot source/destination overlap test used for RAW detection.
module onehot_hazard_cmp #(
    parameter int unsigned NREG = 32
) (
    input  logic [NREG-1:0] i_rd,
    input  logic [NREG-1:0] i_h,
    output logic            o_hit
);

    assign o_hit = |(i_rd & i_h);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// RAW-hazard stall / branch-flush sequencer for the ID stage of the 5-stage pipe.
// Build option: define PIPE_FORWARD_EN when EX/MEM-to-EX forwarding is present.
module pipeline_hazard_ctrl
    import cpu5_ctrl_pkg::*;
#(
    parameter int unsigned BR_FLUSH = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  bus
);

    localparam logic [FL_CNT_W-1:0] FL_RELOAD = FL_CNT_W'(BR_FLUSH - 1);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [FL_CNT_W-1:0]  r_fl_cnt;
    logic [FL_CNT_W-1:0]  w_fl_cnt_nxt;
    logic [NREG-1:0]      r_ex_d;
    logic [NREG-1:0]      r_mem_d;
    logic                 r_ex_ld;
    logic [CNT_W-1:0]     r_hazard_count;

    logic                 w_valid;
    logic [NREG-1:0]      w_rd;
    logic [NREG-1:0]      w_h_ld;
    logic [NREG-1:0]      w_h;
    logic                 w_hit;
    logic                 w_hazard;
    logic                 w_stall;
    logic                 w_flush;
    logic                 w_issue;

    // The IF/ID instruction is discarded while flushing, so it cannot hazard.
    assign w_valid = bus.id_valid & (r_state != ST_FLUSH);
    assign w_rd    = mask_r0(bus.id_aselect | (bus.id_uses_b ? bus.id_bselect : '0));
    assign w_h_ld  = r_ex_ld ? r_ex_d : '0;

`ifdef PIPE_FORWARD_EN
    assign w_h = w_h_ld;
`else
    // Without forwarding every EX and MEM writer blocks; the load term is a subset.
    assign w_h = w_h_ld | r_ex_d | r_mem_d;
`endif

    onehot_hazard_cmp #(.NREG(NREG)) u_cmp (
        .i_rd  (w_rd),
        .i_h   (w_h),
        .o_hit (w_hit)
    );

    assign w_hazard = w_valid & w_hit;

    // An older taken branch overrides the stall of the younger instruction.
    always_comb begin
        w_flush = 1'b0;
        w_stall = 1'b0;
        if (!reset) begin
            w_flush = bus.ex_branch_taken | (r_state == ST_FLUSH);
            w_stall = w_hazard & ~w_flush;
        end
    end

    assign w_issue = bus.id_valid & bus.id_writes & ~w_stall & ~w_flush;

    always_comb begin
        w_state_nxt  = r_state;
        w_fl_cnt_nxt = r_fl_cnt;
        case (r_state)
            ST_RUN, ST_STALL: begin
                if (bus.ex_branch_taken) begin
                    w_state_nxt  = ST_FLUSH;
                    w_fl_cnt_nxt = FL_RELOAD;
                end else if (w_hazard) begin
                    w_state_nxt = ST_STALL;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (bus.ex_branch_taken) begin
                    w_fl_cnt_nxt = FL_RELOAD;
                end else if (r_fl_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_fl_cnt_nxt = r_fl_cnt - FL_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt  = ST_RUN;
                w_fl_cnt_nxt = '0;
            end
        endcase
    end

    // Shadow pipe of in-flight destinations; downstream stages never stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_RUN;
            r_fl_cnt       <= '0;
            r_ex_d         <= '0;
            r_mem_d        <= '0;
            r_ex_ld        <= 1'b0;
            r_hazard_count <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_fl_cnt <= w_fl_cnt_nxt;
            r_ex_d   <= w_issue ? mask_r0(bus.id_dselect) : '0;
            r_ex_ld  <= w_issue & bus.id_load;
            r_mem_d  <= r_ex_d;
            if (w_stall && (r_hazard_count != '1)) begin
                r_hazard_count <= r_hazard_count + CNT_W'(1);
            end
        end
    end

    assign bus.stall        = w_stall;
    assign bus.bubble       = w_stall;
    assign bus.flush        = w_flush;
    assign bus.state        = r_state;
    assign bus.hazard_count = r_hazard_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl (either PIPE_FORWARD_EN setting).
module tb_pipeline_hazard_ctrl;
    import cpu5_ctrl_pkg::*;

    localparam int unsigned TB_CNT_W = 8;
`ifdef PIPE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int S_RUN = 0;
    localparam int S_ST  = 1;
    localparam int S_FL  = 2;

    typedef struct {
        logic rst;
        logic vld;
        int   a;
        int   b;
        logic ub;
        int   d;
        logic wr;
        logic ld;
        logic br;
        int   e_stall;
        int   e_flush;
        int   e_state;
        int   e_cnt;
    } vec_t;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;
    vec_t vt[$];

    pipeline_hazard_ctrl_if #(.CNT_W(TB_CNT_W)) bus ();

    pipeline_hazard_ctrl #(.BR_FLUSH(1), .CNT_W(TB_CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NREG-1:0] oh(input int n);
        logic [NREG-1:0] v;
        v    = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    function automatic vec_t mk(input logic rst, input logic vld, input int a, input int b,
                                input logic ub, input int d, input logic wr, input logic ld,
                                input logic br, input int es, input int ef, input int est,
                                input int ec);
        vec_t v;
        v.rst = rst; v.vld = vld; v.a = a; v.b = b; v.ub = ub; v.d = d;
        v.wr = wr; v.ld = ld; v.br = br;
        v.e_stall = es; v.e_flush = ef; v.e_state = est; v.e_cnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    endtask

    task automatic apply(input vec_t v);
        reset               = v.rst;
        bus.id_valid        = v.vld;
        bus.id_aselect      = oh(v.a);
        bus.id_bselect      = oh(v.b);
        bus.id_uses_b       = v.ub;
        bus.id_dselect      = oh(v.d);
        bus.id_writes       = v.wr;
        bus.id_load         = v.ld;
        bus.ex_branch_taken = v.br;
    endtask

    initial begin
        int p;
        int sp;
        int periods;
        n_chk  = 0;
        n_pass = 0;
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;

        //       rst vld a  b ub  d wr ld br  stall              flush state                cnt
        vt.push_back(mk(1, 1, 3, 0, 0, 3, 1, 0, 0, 0,                 0, S_RUN,               0));
        vt.push_back(mk(1, 1, 3, 3, 1, 3, 1, 0, 0, 0,                 0, S_RUN,               0));
        vt.push_back(mk(1, 1, 3, 3, 1, 3, 1, 0, 1, 0,                 0, S_RUN,               0));
        vt.push_back(mk(0, 1, 1, 2, 1, 3, 1, 0, 0, 0,                 0, S_RUN,               0));
        vt.push_back(mk(0, 1, 3, 4, 1, 6, 1, 0, 0, FWD ? 0 : 1,       0, S_RUN,               0));
        vt.push_back(mk(0, 1, 3, 4, 1, 6, 1, 0, 0, FWD ? 0 : 1,       0, FWD ? S_RUN : S_ST,  FWD ? 0 : 1));
        vt.push_back(mk(0, 1, 3, 4, 1, 6, 1, 0, 0, 0,                 0, FWD ? S_RUN : S_ST,  FWD ? 0 : 2));
        vt.push_back(mk(0, 1, 1, 0, 0, 5, 1, 1, 0, 0,                 0, S_RUN,               FWD ? 0 : 2));
        vt.push_back(mk(0, 1, 2, 5, 1, 7, 1, 0, 0, 1,                 0, S_RUN,               FWD ? 0 : 2));
        vt.push_back(mk(0, 1, 2, 5, 1, 7, 1, 0, 0, FWD ? 0 : 1,       0, S_ST,                FWD ? 1 : 3));
        vt.push_back(mk(0, 1, 2, 5, 1, 7, 1, 0, 0, 0,                 0, FWD ? S_RUN : S_ST,  FWD ? 1 : 4));
        vt.push_back(mk(0, 1, 1, 2, 1, 5, 1, 0, 0, 0,                 0, S_RUN,               FWD ? 1 : 4));
        vt.push_back(mk(0, 1, 1, 5, 0, 5, 1, 0, 0, 0,                 0, S_RUN,               FWD ? 1 : 4));
        vt.push_back(mk(0, 1, 1, 2, 1, 0, 1, 0, 0, 0,                 0, S_RUN,               FWD ? 1 : 4));
        vt.push_back(mk(0, 1, 0, 0, 1, 8, 1, 0, 0, 0,                 0, S_RUN,               FWD ? 1 : 4));
        vt.push_back(mk(0, 0, 8, 0, 0, 9, 1, 0, 0, 0,                 0, S_RUN,               FWD ? 1 : 4));
        vt.push_back(mk(0, 1, 2, 0, 0, 9, 1, 1, 0, 0,                 0, S_RUN,               FWD ? 1 : 4));
        vt.push_back(mk(0, 1, 9, 0, 0, 10, 1, 0, 0, 1,                0, S_RUN,               FWD ? 1 : 4));
        vt.push_back(mk(0, 1, 9, 0, 0, 10, 1, 0, 1, 0,                1, S_ST,                FWD ? 2 : 5));
        vt.push_back(mk(0, 1, 9, 0, 0, 10, 1, 0, 1, 0,                1, S_FL,                FWD ? 2 : 5));
        vt.push_back(mk(0, 1, 9, 0, 0, 10, 1, 0, 0, 0,                1, S_FL,                FWD ? 2 : 5));
        vt.push_back(mk(0, 1, 1, 0, 0, 11, 1, 1, 0, 0,                0, S_RUN,               FWD ? 2 : 5));
        vt.push_back(mk(0, 1, 11, 0, 0, 12, 1, 0, 0, 1,               0, S_RUN,               FWD ? 2 : 5));
        vt.push_back(mk(1, 1, 11, 0, 0, 12, 1, 0, 0, 0,               0, S_ST,                FWD ? 3 : 6));
        vt.push_back(mk(0, 1, 11, 0, 0, 12, 1, 0, 0, 0,               0, S_RUN,               0));

        foreach (vt[i]) begin
            apply(vt[i]);
            @(negedge clk);
            chk("stall",        i, int'(bus.stall),        vt[i].e_stall);
            chk("bubble",       i, int'(bus.bubble),       vt[i].e_stall);
            chk("flush",        i, int'(bus.flush),        vt[i].e_flush);
            chk("state",        i, int'(bus.state),        vt[i].e_state);
            chk("hazard_count", i, int'(bus.hazard_count), vt[i].e_cnt);
            @(posedge clk); #1;
        end

        // Repeating dependent load stream drives hazard_count past its ceiling.
        p       = FWD ? 2 : 3;
        sp      = FWD ? 1 : 2;
        periods = (1 << TB_CNT_W) + 5;
        apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        apply(mk(0, 1, 12, 0, 0, 12, 1, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < periods * p; i++) begin
            if (i == 10 * p) chk("count_mid", i, int'(bus.hazard_count), 10 * sp);
            @(negedge clk);
            chk("sat_stall", i, int'(bus.stall), ((i % p) != 0) ? 1 : 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("count_sat", 0, int'(bus.hazard_count), (1 << TB_CNT_W) - 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
